// File: rtl/imem_loader.sv
// imem_loader: turns a framed UART byte stream into 32-bit instruction-memory
// writes, and holds the datapath in reset until a complete program is loaded.
// Frame: SYNC_BYTE, count N (0 = 256), then N big-endian words.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   clock, resetGral (async, active-high)
//   rx_data/rx_valid : byte strobe from the UART receiver
//   imem_we/imem_addr/imem_wdata : word write port to instruction memory
//   cpu_reset : datapath reset, load_done / load_error : load status
module imem_loader #(
  parameter int         ADDR_W    = 8,
  parameter int         DEPTH     = 256,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 100000
) (
  input  logic              clock,
  input  logic              resetGral,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [1:0]        bcnt_q;
  logic [23:0]       asm_q;
  logic [ADDR_W-1:0] wcnt_q;
  logic [8:0]        left_q;
  logic [TW-1:0]     tmo_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic       sync_hit;
  logic       timed;
  logic       tmo_hit;
  logic       n_ok;
  logic       word_end;
  logic       last_word;
  logic [8:0] n_val;

  assign sync_hit = rx_valid && (rx_data == SYNC_BYTE);
  assign n_val = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
  assign n_ok = ({23'd0, n_val} <= DEPTH_U);

  always_comb begin
    timed = (state_q == COUNT) || (state_q == DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state_q == CSUM) timed = 1'b1;
`endif
  end

  // The cycle that would make the idle count reach TIMEOUT aborts the load.
  assign tmo_hit = timed && !rx_valid && (tmo_q == TLAST);
  assign word_end = (state_q == DATA) && rx_valid && (bcnt_q == 2'd3);
  assign last_word = word_end && (left_q == 9'd1);

  always_ff @(posedge clock or posedge resetGral) begin
    if (resetGral) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (sync_hit) state_d = COUNT;
      end
      COUNT: begin
        if (tmo_hit)       state_d = ERROR;
        else if (rx_valid) state_d = n_ok ? DATA : ERROR;
      end
      DATA: begin
        if (tmo_hit) state_d = ERROR;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else if (last_word) state_d = CSUM;
`else
        else if (last_word) state_d = DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (tmo_hit) state_d = ERROR;
        else if (rx_valid)
          state_d = (rx_data == csum_q) ? DONE : ERROR;
      end
`endif
      DONE, ERROR: begin
        if (sync_hit) state_d = COUNT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge resetGral) begin
    if (resetGral) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      wcnt_q     <= '0;
      left_q     <= '0;
      tmo_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      imem_we <= word_end;
      // Release only after a full cycle spent in DONE with no restart.
      cpu_reset  <= !((state_q == DONE) && (state_d == DONE));
      load_done  <= (state_q == DONE) && (state_d == DONE);
      load_error <= (state_d == ERROR);

      if (rx_valid || !timed) tmo_q <= '0;
      else                    tmo_q <= tmo_q + 1'b1;

      if ((state_q == COUNT) && (state_d == DATA)) begin
        left_q <= n_val;
        wcnt_q <= '0;
        bcnt_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q <= '0;
`endif
      end

      if ((state_q == DATA) && rx_valid) begin
        asm_q  <= {asm_q[15:0], rx_data};
        bcnt_q <= bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q <= csum_q ^ rx_data;
`endif
      end

      if (word_end) begin
        imem_wdata <= {asm_q, rx_data};
        imem_addr  <= wcnt_q;
        wcnt_q     <= wcnt_q + 1'b1;
        left_q     <= left_q - 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model,
// directed scenarios with literal expectations, then randomized frames.
module tb_imem_loader;

  localparam int         AW  = 4;
  localparam int         DEP = 16;
  localparam int         TMO = 50;
  localparam logic [7:0] SYN = 8'hA5;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam int M_HUNT = 0;
  localparam int M_CNT  = 1;
  localparam int M_DAT  = 2;
  localparam int M_SUM  = 3;
  localparam int M_OK   = 4;
  localparam int M_BAD  = 5;

  logic          clock;
  logic          resetGral;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          load_done;
  logic          load_error;

  imem_loader #(
    .ADDR_W(AW), .DEPTH(DEP), .SYNC_BYTE(SYN), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .resetGral(resetGral),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_error(load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic rst_drv;

  int m_mode, m_n, m_got, m_gap;
  logic [7:0] m_sum;
  logic [7:0] m_cur[$];
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdata;
  logic          e_crst, e_done, e_err;

  logic [AW-1:0] wl_addr[$];
  logic [31:0]   wl_data[$];
  logic [7:0]    bq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = M_HUNT; m_gap = 0; m_n = 0; m_got = 0; m_sum = 0;
    m_cur.delete();
    e_we = 0; e_addr = '0; e_wdata = '0;
    e_crst = 1; e_done = 0; e_err = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d,
                            input bit r);
    int prev, n;
    if (r) begin
      model_reset();
      return;
    end
    prev = m_mode;
    e_we = 0;
    case (m_mode)
      M_HUNT: if (v && d == SYN) begin m_mode = M_CNT; m_gap = 0; end
      M_CNT: if (v) begin
        n = (d == 0) ? 256 : int'(d);
        if (n > DEP) m_mode = M_BAD;
        else begin
          m_mode = M_DAT; m_n = n; m_got = 0; m_sum = 0;
          m_cur.delete();
        end
      end
      M_DAT: if (v) begin
        m_cur.push_back(d);
        m_sum ^= d;
        if (m_cur.size() == 4) begin
          e_we = 1;
          e_addr = AW'(m_got);
          e_wdata = {m_cur[0], m_cur[1], m_cur[2], m_cur[3]};
          m_got++;
          m_cur.delete();
          if (m_got == m_n) m_mode = CSUM_EN ? M_SUM : M_OK;
        end
      end
      M_SUM: if (v) m_mode = (d == m_sum) ? M_OK : M_BAD;
      default: if (v && d == SYN) begin m_mode = M_CNT; m_gap = 0; end
    endcase
    if (prev == M_CNT || prev == M_DAT || prev == M_SUM) begin
      if (v) m_gap = 0;
      else begin
        m_gap++;
        if (m_gap == TMO) m_mode = M_BAD;
      end
    end
    e_done = (prev == M_OK) && (m_mode == M_OK);
    e_crst = !e_done;
    e_err = (m_mode == M_BAD);
  endtask

  task automatic cyc(input bit v, input logic [7:0] d);
    @(negedge clock);
    resetGral = rst_drv;
    rx_valid = v;
    rx_data = d;
    @(posedge clock);
    #1;
    model_step(v, d, resetGral);
    if (imem_we === 1'b1) begin
      wl_addr.push_back(imem_addr);
      wl_data.push_back(imem_wdata);
    end
    chk("imem_we", 32'(imem_we), 32'(e_we));
    chk("imem_addr", 32'(imem_addr), 32'(e_addr));
    chk("imem_wdata", imem_wdata, e_wdata);
    chk("cpu_reset", 32'(cpu_reset), 32'(e_crst));
    chk("load_done", 32'(load_done), 32'(e_done));
    chk("load_error", 32'(load_error), 32'(e_err));
  endtask

  task automatic flush_bq();
    foreach (bq[i]) cyc(1, bq[i]);
    bq.delete();
  endtask

  task automatic add_csum();
    logic [7:0] s;
    s = 0;
    for (int i = 2; i < bq.size(); i++) s ^= bq[i];
    if (CSUM_EN) bq.push_back(s);
  endtask

  task automatic clr_log();
    wl_addr.delete();
    wl_data.delete();
  endtask

  function automatic int rgap();
    int r;
    r = int'($urandom_range(0, 59));
    if (r == 0) return int'($urandom_range(45, 55));
    if (r < 40) return 0;
    return int'($urandom_range(1, 3));
  endfunction

  task automatic send(input logic [7:0] b);
    int g;
    g = rgap();
    repeat (g) cyc(0, 8'($urandom));
    cyc(1, b);
  endtask

  initial begin
    int k, nb;
    logic [7:0] b, s;
    rst_drv = 1; resetGral = 1; rx_valid = 0; rx_data = 0;
    model_reset();
    repeat (3) cyc(0, 8'h00);
    rst_drv = 0;
    cyc(0, 8'h00);

    // reset mid-DATA, asynchronous off-edge
    bq = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    flush_bq();
    @(negedge clock);
    #2 rst_drv = 1; resetGral = 1; rx_valid = 0;
    #1;
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_error", 32'(load_error), 0);
    model_reset();
    repeat (2) cyc(0, 8'h00);
    rst_drv = 0;

    // basic back-to-back load
    clr_log();
    bq = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
           8'h8C, 8'h09, 8'h00, 8'h04};
    add_csum();
    flush_bq();
    cyc(0, 8'h00);
    chk("basic_nwr", wl_addr.size(), 2);
    if (wl_addr.size() == 2) begin
      chk("basic_a0", 32'(wl_addr[0]), 0);
      chk("basic_d0", wl_data[0], 32'h20080005);
      chk("basic_a1", 32'(wl_addr[1]), 1);
      chk("basic_d1", wl_data[1], 32'h8C090004);
    end
    chk("basic_done", 32'(load_done), 1);
    chk("basic_cpu_reset", 32'(cpu_reset), 0);

    // noise then one-word frame, then restart
    clr_log();
    bq = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01,
           8'hDE, 8'hAD, 8'hBE, 8'hEF};
    add_csum();
    bq = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01,
           8'hDE, 8'hAD, 8'hBE, 8'hEF};
    if (CSUM_EN) bq.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
    flush_bq();
    cyc(0, 8'h00);
    chk("noise_nwr", wl_addr.size(), 1);
    chk("noise_done", 32'(load_done), 1);
    clr_log();
    cyc(1, 8'hA5);
    chk("restart_cpu_reset", 32'(cpu_reset), 1);
    chk("restart_done", 32'(load_done), 0);
    bq = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    add_csum();
    bq.delete(0);
    flush_bq();
    cyc(0, 8'h00);
    chk("restart_nwr", wl_addr.size(), 1);
    if (wl_addr.size() == 1) begin
      chk("restart_a0", 32'(wl_addr[0]), 0);
      chk("restart_d0", wl_data[0], 0);
    end
    chk("restart_done2", 32'(load_done), 1);

    // overflow: 17 words with DEPTH 16
    clr_log();
    cyc(1, 8'hA5);
    cyc(1, 8'h11);
    chk("ovf_error", 32'(load_error), 1);
    chk("ovf_cpu_reset", 32'(cpu_reset), 1);
    cyc(0, 8'h00);
    chk("ovf_nwr", wl_addr.size(), 0);
    bq = '{8'hA5, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    add_csum();
    flush_bq();
    cyc(0, 8'h00);
    chk("ovf_clear", 32'(load_error), 0);
    chk("ovf_done", 32'(load_done), 1);

    // timeout after three data bytes
    clr_log();
    bq = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03};
    flush_bq();
    k = 1;
    while (k <= 200) begin
      cyc(0, 8'h00);
      if (load_error === 1'b1) break;
      k++;
    end
    chk("tmo_gap", k, TMO);
    chk("tmo_nwr", wl_addr.size(), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    clr_log();
    bq = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    flush_bq();
    cyc(0, 8'h00);
    chk("csum_ok_done", 32'(load_done), 1);
    clr_log();
    bq = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    flush_bq();
    cyc(0, 8'h00);
    chk("csum_bad_nwr", wl_addr.size(), 1);
    chk("csum_bad_err", 32'(load_error), 1);
    chk("csum_bad_cpu_reset", 32'(cpu_reset), 1);
`endif

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == SYN) b = 8'h00;
        send(b);
      end
      send(SYN);
      k = int'($urandom_range(0, 11));
      if (k == 0)      nb = 0;
      else if (k == 1) nb = int'($urandom_range(17, 255));
      else             nb = int'($urandom_range(1, 16));
      send(8'(nb));
      if (nb >= 1 && nb <= DEP) begin
        s = 0;
        for (int i = 0; i < nb * 4; i++) begin
          b = 8'($urandom);
          s ^= b;
          send(b);
        end
        if (CSUM_EN) begin
          if ($urandom_range(0, 3) == 0) s ^= 8'h01;
          send(s);
        end
      end
      repeat (2) cyc(0, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
